// File: rtl/hazard_stall_controller.sv
// Hazard and stall controller for a 5-stage in-order pipeline.
// Detects load-use, multi-cycle multiply and taken-branch hazards,
// drives PC/IF-ID enables, flush, bubble and hold controls, selects
// ALU operand forwarding, and counts stall cycles (saturating).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_rs/id_rt         ID source registers, id_use_rs/id_use_rt read flags
//   ex_rs/ex_rt/ex_rd   EX registers; ex_reg_write, ex_mem_read, ex_is_mul
//   mem_rd/wb_rd        later-stage destinations with write enables
//   ex_branch_taken     branch/jump resolved taken in EX
//   pc_write/ifid_write PC and IF/ID update enables
//   ifid_flush          zero IF/ID
//   idex_bubble         insert bubble into ID/EX
//   ex_hold             hold ID/EX and EX
//   fwd_a/fwd_b         operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   state               current FSM state
//   stall_cycles        count of cycles with pc_write low
module hazard_stall_controller #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_is_mul,
    input  logic [4:0]  mem_rd,
    input  logic [4:0]  wb_rd,
    input  logic        mem_reg_write,
    input  logic        wb_reg_write,
    input  logic        ex_branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        ex_hold,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [1:0]  state,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MUL_BUSY   = 2'b10,
        FLUSH      = 2'b11
    } state_e;

    // The RUN cycle that detects the multiply is itself a stall cycle,
    // so the counter covers the remaining MUL_CYCLES-2 hold cycles.
    localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 2);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic        load_use;

    // ex_reg_write does not affect stall decisions; a load always writes.
    logic unused_ok;
    assign unused_ok = ex_reg_write;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == src)
            return 2'b10;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign load_use = ex_mem_read && ex_rd != 5'd0 &&
                      ((id_use_rs && id_rs == ex_rd) ||
                       (id_use_rt && id_rt == ex_rd));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        ex_hold     = 1'b0;
        fwd_a       = fwd_sel(ex_rs);
        fwd_b       = fwd_sel(ex_rt);

        unique case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = FLUSH;
                end else if (ex_is_mul) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    ex_hold    = 1'b1;
                    cnt_d      = CNT_INIT;
                    state_d    = MUL_BUSY;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    state_d     = LOAD_STALL;
                end
            end
            LOAD_STALL: begin
                if (ex_branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            MUL_BUSY: begin
                if (cnt_q != 4'd0) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    ex_hold    = 1'b1;
                    cnt_d      = cnt_q - 4'd1;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Reset overrides everything so the pipeline runs freely.
        if (rst) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            ex_hold     = 1'b0;
            fwd_a       = 2'b00;
            fwd_b       = 2'b00;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_write && !(&stall_cycles_q))
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            cnt_q          <= 4'd0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign state        = state_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, meaning cycles a multiply occupies EX (legal range 2..15).
REQ-002 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports id_rs, id_rt  in  5 each  ID-stage source registers; id_use_rs, id_use_rt  in  1 each  source actually read.
REQ-005 SHALL have ports ex_rs, ex_rt, ex_rd  in  5 each  EX-stage registers; ex_reg_write, ex_mem_read, ex_is_mul  in  1 each.
REQ-006 SHALL have ports mem_rd, wb_rd  in  5 each  and mem_reg_write, wb_reg_write  in  1 each  destinations of later stages.
REQ-007 SHALL have port ex_branch_taken  in  1  branch/jump resolved taken in EX.
REQ-008 SHALL have ports pc_write, ifid_write  out  1 each  enable PC and IF/ID update.
REQ-009 SHALL have ports ifid_flush, idex_bubble, ex_hold  out  1 each  zero IF/ID, insert bubble into ID/EX, hold ID/EX and EX.
REQ-010 SHALL have ports fwd_a, fwd_b  out  2 each  ALU operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-011 SHALL have ports state  out  2  current FSM state; stall_cycles  out  32  stall-cycle count.

Function
REQ-012 SHALL implement FSM states RUN=00, LOAD_STALL=01, MUL_BUSY=10, FLUSH=11.
REQ-013 SHALL define defaults in every cycle as: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, ex_hold=0.
REQ-014 SHALL define load-use hazard as: ex_mem_read, ex_rd!=0, and ((id_use_rs and id_rs==ex_rd) or (id_use_rt and id_rt==ex_rd)).
REQ-015 SHALL, in RUN and LOAD_STALL, apply the first matching case by priority: branch, then multiply (RUN only), then load-use (RUN only).
REQ-016 SHALL, on ex_branch_taken, drive ifid_flush=1 and idex_bubble=1 in that same cycle, keep pc_write=1, and go to FLUSH.
REQ-017 SHALL treat FLUSH as a one-cycle state with defaults, no hazard detection, and return to RUN.
REQ-018 SHALL, on ex_is_mul in RUN, drive pc_write=0, ifid_write=0 and ex_hold=1 in that same cycle, load cnt with MUL_CYCLES-2, and go to MUL_BUSY.
REQ-019 SHALL, in MUL_BUSY with cnt!=0, drive pc_write=0, ifid_write=0 and ex_hold=1, and decrement cnt.
REQ-020 SHALL, in MUL_BUSY with cnt==0, drive defaults and return to RUN, giving exactly MUL_CYCLES-1 stall cycles per multiply.
REQ-021 SHALL ignore ex_branch_taken, ex_is_mul and load-use in MUL_BUSY.
REQ-022 SHALL, on load-use in RUN, drive pc_write=0, ifid_write=0 and idex_bubble=1 in that same cycle, and go to LOAD_STALL.
REQ-023 SHALL, in LOAD_STALL without a branch, drive defaults and return to RUN, giving exactly one bubble per load-use.
REQ-024 SHALL treat ex_mem_read and ex_is_mul both high as a multiply.
REQ-025 SHALL set fwd_a=10 when mem_reg_write, mem_rd!=0 and mem_rd==ex_rs; otherwise 01 when wb_reg_write, wb_rd!=0 and wb_rd==ex_rs; otherwise 00.
REQ-026 SHALL compute fwd_b by the same rule using ex_rt; fwd_a and fwd_b are combinational and valid in all states.
REQ-027 SHALL increment stall_cycles in every cycle that pc_write=0, saturating at 0xFFFFFFFF without wrapping.

Reset
REQ-028 SHALL, on a clock edge with rst=1, set state=RUN, cnt=0 and stall_cycles=0.
REQ-029 SHALL, while rst=1, drive pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, ex_hold=0, fwd_a=00 and fwd_b=00.
REQ-030 SHALL, on reset in any state including MUL_BUSY, abandon the operation; the first cycle after rst falls is RUN.

Verification
REQ-031 SHALL be verified: lw $t0 in EX, ID reads $t0 -> one cycle pc_write=0/idex_bubble=1, state 01 next, stall_cycles=1.
REQ-032 SHALL be verified: mul in EX, MUL_CYCLES=4 -> pc_write=0 for exactly 3 cycles, states 00,10,10,10, then RUN; stall_cycles=3.
REQ-033 SHALL be verified: ex_branch_taken with a load-use also present -> ifid_flush=1, idex_bubble=1, pc_write=1, state 11 next, stall_cycles unchanged.
REQ-034 SHALL be verified: mem_rd=wb_rd=ex_rs=9, both writes set -> fwd_a=10; with ex_rs=0 -> fwd_a=00.
REQ-035 SHALL be verified: rst asserted in the second MUL_BUSY cycle -> next state RUN, stall_cycles=0, pc_write=1.
REQ-036 SHALL be verified: stall_cycles forced to 0xFFFFFFFE with two further stall cycles -> value holds at 0xFFFFFFFF.
